// File: rtl/int_div_unit_pkg.sv
// Shared types and constants for the integer divider and its handshake partners.
package riscv_types;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_t;

    localparam int DIV_LATENCY = 33;
    localparam int DIV_ITER    = 32;
    // Position of the divider in the p_signal_start_exe / p_signal_last vectors.
    localparam int P_DIV_IDX   = 3;

    function automatic logic is_signed_op(input div_op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_quo_op(input div_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/int_div_unit_div_step.sv
// One radix-2 restoring division step on the {rem, quo} shift pair.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] rem_ext;
    logic [XLEN:0] trial;
    logic          trial_ok;

    // The shifted remainder can need XLEN+1 bits; a clear borrow bit means trial >= 0.
    assign rem_ext  = {rem, quo[XLEN-1]};
    assign trial    = rem_ext - {1'b0, divisor};
    assign trial_ok = ~trial[XLEN];

    assign rem_next = trial_ok ? trial[XLEN-1:0] : rem_ext[XLEN-1:0];
    assign quo_next = {quo[XLEN-2:0], trial_ok};

endmodule

// File: rtl/int_div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU with start/last handshake.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip iteration.
import riscv_types::*;

module int_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            p_start,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    input  logic            hold,
    output logic            busy,
    output logic [4:0]      rd_busy_tag,
    output logic            p_last,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    state_t           state_q, state_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  divisor_q, divisor_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    div_op_t          op_q, op_d;
    logic [4:0]       rd_q, rd_d;

    div_op_t         in_op;
    logic            in_signed;
    logic            rs2_zero;
    logic [XLEN-1:0] abs_rs1;
    logic [XLEN-1:0] abs_rs2;
    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_quo;
    logic [XLEN-1:0] final_quo;
    logic [XLEN-1:0] final_rem;

    assign in_op     = div_op_t'(div_op);
    assign in_signed = is_signed_op(in_op);
    assign rs2_zero  = (rs2_data == '0);
    assign abs_rs1   = (in_signed && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
    assign abs_rs2   = (in_signed && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;

    div_step #(.XLEN(XLEN)) u_div_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (divisor_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    assign final_quo = qsign_q ? -step_quo : step_quo;
    assign final_rem = rsign_q ? -step_rem : step_rem;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        result_d  = result_q;
        count_d   = count_q;
        qsign_d   = qsign_q;
        rsign_d   = rsign_q;
        op_d      = op_q;
        rd_d      = rd_q;

        case (state_q)
            S_IDLE: begin
                if (p_start) begin
                    quo_d     = abs_rs1;
                    rem_d     = '0;
                    divisor_d = abs_rs2;
                    count_d   = '0;
                    // A zero divisor must yield all ones, so its quotient is never negated.
                    qsign_d   = (in_op == OP_DIV) && (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]) && !rs2_zero;
                    rsign_d   = (in_op == OP_REM) && rs1_data[XLEN-1];
                    op_d      = in_op;
                    rd_d      = rd_in;
                    state_d   = S_ITER;
`ifdef DIV_EARLY_OUT_EN
                    if (rs2_zero) begin
                        result_d = is_quo_op(in_op) ? '1 : rs1_data;
                        state_d  = S_DONE;
                    end else if (in_signed && rs1_data == INT_MIN && rs2_data == '1) begin
                        result_d = (in_op == OP_DIV) ? INT_MIN : '0;
                        state_d  = S_DONE;
                    end
`endif
                end
            end
            S_ITER: begin
                rem_d   = step_rem;
                quo_d   = step_quo;
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_STEP) begin
                    result_d = is_quo_op(op_q) ? final_quo : final_rem;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (!hold) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A killed operation must not disturb the previously delivered result.
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            result_q  <= '0;
            count_q   <= '0;
            qsign_q   <= 1'b0;
            rsign_q   <= 1'b0;
            op_q      <= OP_DIV;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            result_q  <= result_d;
            count_q   <= count_d;
            qsign_q   <= qsign_d;
            rsign_q   <= rsign_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign p_last      = (state_q == S_DONE);
    assign result      = result_q;
    assign rd_busy_tag = rd_q;

endmodule

// File: tb/tb_int_div_unit.sv
// Directed self-checking bench for int_div_unit: latency, sign handling, hold, flush, reset.
import riscv_types::*;

module tb_int_div_unit;

    logic        clk;
    logic        reset_n;
    logic        p_start;
    logic [1:0]  div_op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_in;
    logic        flush;
    logic        hold;
    logic        busy;
    logic [4:0]  rd_busy_tag;
    logic        p_last;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 33;
`endif

    int_div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .p_start     (p_start),
        .div_op      (div_op),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .rd_in       (rd_in),
        .flush       (flush),
        .hold        (hold),
        .busy        (busy),
        .rd_busy_tag (rd_busy_tag),
        .p_last      (p_last),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Caller is 1ns after a rising edge (cycle N); returns 1ns into cycle N+lat+1.
    task automatic run_op(input string name, input div_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int lat);
        div_op   = op;
        rs1_data = a;
        rs2_data = b;
        rd_in    = rd;
        p_start  = 1'b1;
        for (int k = 1; k <= lat; k++) begin
            next_cycle();
            p_start = 1'b0;
            if (k == 1) check({name, " busy"}, 32'(busy), 32'd1);
            if (k == 1) check({name, " rd_tag"}, 32'(rd_busy_tag), 32'(rd));
            if (k == lat || k == lat - 1) check({name, " p_last"}, 32'(p_last), 32'(k == lat));
        end
        check({name, " busy_at_last"}, 32'(busy), 32'd1);
        check({name, " result"}, result, exp);
        next_cycle();
        check({name, " busy_after"}, 32'(busy), 32'd0);
        check({name, " p_last_after"}, 32'(p_last), 32'd0);
        check({name, " result_kept"}, result, exp);
        $display("op %-12s a=%h b=%h result=%h expected=%h", name, a, b, result, exp);
    endtask

    initial begin
        reset_n  = 1'b0;
        p_start  = 1'b0;
        div_op   = 2'd0;
        rs1_data = '0;
        rs2_data = '0;
        rd_in    = '0;
        flush    = 1'b0;
        hold     = 1'b0;
        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset p_last", 32'(p_last), 32'd0);
        check("reset result", result, 32'd0);
        check("reset rd_tag", 32'(rd_busy_tag), 32'd0);
        reset_n = 1'b1;
        next_cycle();

        run_op("div_neg", OP_DIV, 32'hFFFF_FFEC, 32'd3, 5'd7, 32'hFFFF_FFFA, 33);
        run_op("rem_neg", OP_REM, 32'hFFFF_FFEC, 32'd3, 5'd8, 32'hFFFF_FFFE, 33);
        run_op("div_negdvs", OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd9, 32'hFFFF_FFFD, 33);
        run_op("rem_negdvs", OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd10, 32'd1, 33);
        run_op("divu", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 5'd11, 32'h0FFF_FFFF, 33);
        run_op("remu", OP_REMU, 32'hFFFF_FFFF, 32'h10, 5'd12, 32'hF, 33);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, SPECIAL_LAT);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, SPECIAL_LAT);
        run_op("divu_noovf", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 33);
        run_op("remu_noovf", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 33);
        run_op("div_by0", OP_DIV, 32'hFFFF_FFEC, 32'd0, 5'd17, 32'hFFFF_FFFF, SPECIAL_LAT);
        run_op("divu_by0", OP_DIVU, 32'd100, 32'd0, 5'd18, 32'hFFFF_FFFF, SPECIAL_LAT);
        run_op("rem_by0", OP_REM, 32'hFFFF_FFEC, 32'd0, 5'd19, 32'hFFFF_FFEC, SPECIAL_LAT);
        run_op("remu_by0", OP_REMU, 32'h1234, 32'd0, 5'd20, 32'h1234, SPECIAL_LAT);

        // hold for 5 cycles starting at N+33
        div_op = OP_DIVU; rs1_data = 32'd1000; rs2_data = 32'd7; rd_in = 5'd21; p_start = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            next_cycle();
            p_start = 1'b0;
        end
        check("hold pre p_last", 32'(p_last), 32'd0);
        next_cycle();
        hold = 1'b1;
        for (int k = 33; k <= 38; k++) begin
            if (k == 38) hold = 1'b0;
            check("hold p_last", 32'(p_last), 32'd1);
            check("hold result", result, 32'd142);
            check("hold busy", 32'(busy), 32'd1);
            next_cycle();
        end
        check("hold exit p_last", 32'(p_last), 32'd0);
        check("hold exit busy", 32'(busy), 32'd0);
        $display("op %-12s held 5 cycles result=%h", "hold", result);
        run_op("after_hold", OP_REMU, 32'd1000, 32'd7, 5'd22, 32'd6, 33);

        // flush at N+10 kills the operation without a p_last pulse
        div_op = OP_DIV; rs1_data = 32'd500; rs2_data = 32'd5; rd_in = 5'd23; p_start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            next_cycle();
            p_start = 1'b0;
        end
        check("flush pre busy", 32'(busy), 32'd1);
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        check("flush busy", 32'(busy), 32'd0);
        check("flush p_last", 32'(p_last), 32'd0);
        for (int k = 0; k < 30; k++) begin
            next_cycle();
            check("flush no_last", 32'(p_last), 32'd0);
        end
        check("flush result_kept", result, 32'd6);
        $display("op %-12s killed at N+10 result=%h", "flush", result);

        // asynchronous reset in the middle of ITER
        div_op = OP_DIVU; rs1_data = 32'd99; rs2_data = 32'd9; rd_in = 5'd24; p_start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            p_start = 1'b0;
        end
        check("rst pre busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst p_last", 32'(p_last), 32'd0);
        check("rst result", result, 32'd0);
        check("rst rd_tag", 32'(rd_busy_tag), 32'd0);
        $display("op %-12s mid-ITER reset busy=%0d result=%h", "reset", busy, result);
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
        run_op("after_rst", OP_DIVU, 32'd99, 32'd9, 5'd25, 32'd11, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/int_div_unit.md
Name: int_div_unit

Overview:
- Iterative radix-2 restoring integer divider for DIV/DIVU/REM/REMU in the EXE stage.
- Responder side of the priority start/last handshake:
  - accepts a one-cycle start from the priority decoder path (p_signal_start_exe bit);
  - reports busy to the control unit (div_unit_busy);
  - returns a one-cycle last pulse (p_signal_last bit) with the result to the priority controller / EXE result mux.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  core clock.
- reset_n  input  1  asynchronous active-low reset.
- p_start  input  1  start strobe; operands and op are valid in this cycle.
- div_op  input  2  div_op_t: DIV=0, DIVU=1, REM=2, REMU=3.
- rs1_data  input  XLEN  dividend.
- rs2_data  input  XLEN  divisor.
- rd_in  input  5  destination register tag.
- flush  input  1  kill the in-flight operation (branch/jump redirect).
- hold  input  1  downstream stall; freeze the DONE state.
- busy  output  1  to div_unit_busy; high in ITER and DONE.
- rd_busy_tag  output  5  rd of the in-flight operation; valid while busy.
- p_last  output  1  result valid; one-cycle pulse, extended while hold is high.
- result  output  XLEN  quotient or remainder.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busy=0; p_last=0; result=0; rd_busy_tag=0; all internal registers 0.
- FSM states: IDLE, ITER, DONE.
- IDLE:
  - On p_start=1 & flush=0, capture:
    - |rs1| and |rs2| (signed ops) or the raw values (unsigned ops);
    - the quotient sign = rs1[31]^rs2[31] (DIV only);
    - the remainder sign = rs1[31] (REM only);
    - div_op and rd_in.
  - Clear the remainder register, set count=0, go to ITER.
  - p_start while not IDLE is ignored; the control unit guarantees none via busy.
- ITER:
  - One step per cycle: {rem,quo} shifted left 1; trial = rem - divisor; if trial ≥ 0 then rem=trial and quo[0]=1.
  - count increments each step; after step XLEN-1 (count=31) go to DONE.
  - Exactly XLEN=32 ITER cycles.
- DONE:
  - p_last=1; result is registered with sign correction already applied.
  - If hold=0, go to IDLE next cycle. If hold=1, stay in DONE with p_last and result stable.
- Latency: p_start at cycle N; p_last high in cycle N+33 (hold=0); busy low in cycle N+34.
- Back-to-back: a new p_start is accepted in the first cycle after DONE exits; the minimum start-to-start spacing is 34 cycles.
- Sign correction: negate the quotient if the quotient sign is 1; negate the remainder if the remainder sign is 1.
- Divide by zero (rs2=0):
  - DIV/DIVU result = all ones (0xFFFFFFFF);
  - REM/REMU result = rs1 unmodified;
  - still takes the full 33-cycle latency.
- Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF):
  - DIV result = 0x80000000;
  - REM result = 0;
  - full latency.
- flush:
  - In any state: next state IDLE, busy=0, p_last=0 the next cycle.
  - flush takes priority over p_start and hold in the same cycle.
- result keeps its last value while in IDLE and is consumed only when p_last=1.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: the divide-by-zero and signed-overflow cases bypass ITER. IDLE→DONE directly, so p_last is high in cycle N+1 with the same result values as above.
- Undefined: every operation takes the uniform 33-cycle latency. The control unit must tolerate both.

Decomposition:
- riscv_types package:
  - div_op_t enum;
  - constants DIV_LATENCY=33 and DIV_ITER=32;
  - the bit index of the divider in the p_signal vectors (P_DIV_IDX).
- Sub-module div_step:
  - combinational one-bit restoring step;
  - inputs: rem, quo, divisor;
  - outputs: next rem and next quo.
- int_div_unit holds the FSM, the counter and sign handling.

Test Plan:
- DIV rs1=-20 (0xFFFFFFEC), rs2=3 → p_last at N+33, result=0xFFFFFFFA (-6); REM on the same operands → 0xFFFFFFFE (-2); busy high N+1..N+33.
- DIVU 0xFFFFFFFF / 0x10 → 0x0FFFFFFF; REMU → 0xF.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0.
  - DIV_EARLY_OUT_EN defined: p_last at N+1.
  - Undefined: p_last at N+33.
- DIV x/0 → 0xFFFFFFFF; REMU 0x1234/0 → 0x1234.
- hold=1 for 5 cycles from N+33 → p_last and result stable through N+38; state returns to IDLE at N+39.
  - Then a p_start at N+39 is accepted and completes at N+72.
- flush asserted at N+10 → busy=0 and p_last=0 from N+11; no p_last pulse appears.
  - reset_n pulsed low mid-ITER → all outputs 0 immediately.
